// File: rtl/spram_reader_if.sv
// spram_reader_if: Avalon-MM bus toward the RAM slave plus the valid/ready output stream.
interface spram_reader_if #(parameter int DATA_W = 32);
  logic [2:0]        avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, out_data, out_valid,
    input  avm_readdata, out_ready
  );
  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, out_data, out_valid,
    output avm_readdata, out_ready
  );
endinterface

// File: rtl/spram_reader.sv
// spram_reader: checks the RAM slave ID, programs its pointer, then streams a block of words out.
module spram_reader #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 11,
  parameter int          LEN_W   = 12,
  parameter logic [31:0] ID_WORD = 32'h87654321
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              error,
  spram_reader_if.master    bus
);
  typedef enum logic [3:0] {IDLE, ID_RD, ID_CHK, SET_ADDR, SETTLE, RD, CAPT, OUT, DONE} state_t;
  state_t state, next;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  rem;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:     if (start) next = length == '0 ? DONE : ID_RD;
      ID_RD:    next = ID_CHK;
      ID_CHK:   next = bus.avm_readdata != ID_WORD ? DONE : SET_ADDR;
      SET_ADDR: next = SETTLE;
      SETTLE:   next = RD;
      RD:       next = CAPT;
      CAPT:     next = OUT;
      OUT:      if (bus.out_ready) next = rem == '0 ? DONE : RD;
      DONE:     next = IDLE;
      default:  next = IDLE;
    endcase
  end
  // Strobes decode straight from state so an async reset drops them immediately.
  always_comb begin
    bus.avm_read      = state == ID_RD || state == RD;
    bus.avm_write     = state == SET_ADDR;
    bus.avm_address   = state == ID_RD ? 3'd3 : state == SET_ADDR ? 3'd1 : 3'd0;
    bus.avm_writedata = state == SET_ADDR ? 32'(base) : 32'd0;
    busy              = state != IDLE;
    done              = state == DONE;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      base          <= '0;
      rem           <= '0;
      error         <= 1'b0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        base  <= base_addr;
        rem   <= length;
        error <= 1'b0;
      end
      if (state == ID_CHK && bus.avm_readdata != ID_WORD) error <= 1'b1;
      if (state == CAPT) begin
        bus.out_data  <= bus.avm_readdata[DATA_W-1:0];
        bus.out_valid <= 1'b1;
        rem           <= rem - 1'b1;
      end
      if (state == OUT && bus.out_ready) bus.out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_spram_reader.sv
// tb_spram_reader: directed and random jobs against a RAM slave model and a block-read reference.
module tb_spram_reader;
  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [10:0] base_addr;
  logic [11:0] length;
  logic        busy, done, error;
  logic        bad_id = 1'b0;
  logic [31:0] ram [2048];
  logic [10:0] ptr;
  logic        prev_rd0 = 1'b0;
  logic [31:0] last_wd = '0;
  int rd0 = 0, wr = 0, viol = 0;
  int total = 0, bad = 0;
  spram_reader_if bus ();
  spram_reader dut (
    .clock(clock), .resetn(resetn), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .error(error), .bus(bus)
  );
  always #5 clock = ~clock;
  wire rd0_now = bus.avm_read && bus.avm_address == 3'd0;
  // Slave: registered read data, pointer auto-increments on each data-register read.
  always @(posedge clock) begin
    viol <= viol + int'(bus.avm_read && bus.avm_write)
                 + int'(!bus.avm_read && !bus.avm_write && (bus.avm_address != 0 || bus.avm_writedata != 0))
                 + int'(rd0_now && prev_rd0);
    prev_rd0 <= rd0_now;
    if (rd0_now) begin
      rd0              <= rd0 + 1;
      bus.avm_readdata <= ram[ptr];
      ptr              <= ptr + 11'd1;
    end else if (bus.avm_read && bus.avm_address == 3'd3)
      bus.avm_readdata <= bad_id ? 32'hDEADBEEF : 32'h87654321;
    if (bus.avm_write && bus.avm_address == 3'd1) begin
      wr      <= wr + 1;
      last_wd <= bus.avm_writedata;
      ptr     <= bus.avm_writedata[10:0];
    end
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string ctx);
    chk({ctx, "_busy"}, 32'(busy), 0);
    chk({ctx, "_done"}, 32'(done), 0);
    chk({ctx, "_error"}, 32'(error), 0);
    chk({ctx, "_valid"}, 32'(bus.out_valid), 0);
    chk({ctx, "_strobes"}, {30'd0, bus.avm_read, bus.avm_write}, 0);
    chk({ctx, "_addr"}, 32'(bus.avm_address), 0);
    chk({ctx, "_wdata"}, bus.avm_writedata, 0);
    chk({ctx, "_data"}, bus.out_data, 0);
  endtask
  // mode 0: ready always high, 1: ready one cycle in four, 2: random ready
  task automatic run_job(input int b, input int n, input int mode, input bit exp_err, input bit inject);
    logic [31:0] q[$];
    logic [31:0] prev_data = '0;
    int rd0_s = rd0, wr_s = wr, viol_s = viol;
    int cyc = 1, first = -1, done_cyc = -1, got = 0, busy_bad = 0, err_bad = 0, stab_bad = 0;
    int exp_done, obs_done;
    bit stalled = 0, ok = !exp_err && n != 0;
    for (int i = 0; i < n; i++) q.push_back(ram[(b + i) % 2048]);
    start = 1'b1; base_addr = 11'(b); length = 12'(n);
    tick();
    start = 1'b0;
    while (cyc < 400) begin
      if (inject && cyc == 4) begin
        start = 1'b1; base_addr = 11'(b + 7); length = 12'd9;
      end else start = 1'b0;
      bus.out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0) : 1'($urandom_range(0, 1));
      if (busy !== 1'b1) busy_bad++;
      if (error !== (exp_err && cyc >= 3)) err_bad++;
      if (bus.out_valid === 1'b1) begin
        if (first < 0) first = cyc;
        if (stalled && bus.out_data !== prev_data) stab_bad++;
        if (bus.out_ready) begin
          got++;
          if (q.size() == 0) chk("extra_word", 1, 0);
          else chk("data", bus.out_data, q.pop_front());
        end
      end
      stalled = bus.out_valid === 1'b1 && !bus.out_ready;
      prev_data = bus.out_data;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    exp_done = n == 0 ? 1 : exp_err ? 3 : 3 * n + 5;
    obs_done = (mode != 0 && ok && done_cyc >= exp_done) ? exp_done : done_cyc;
    chk("done_cycle", obs_done, exp_done);
    chk("words", got, ok ? n : 0);
    chk("first_valid", first, ok ? 7 : -1);
    chk("busy_during", busy_bad, 0);
    chk("error_during", err_bad, 0);
    chk("stable", stab_bad, 0);
    tick();
    chk("busy_after", 32'(busy), 0);
    chk("done_after", 32'(done), 0);
    chk("error_after", 32'(error), 32'(exp_err));
    chk("rd0_count", rd0 - rd0_s, ok ? n : 0);
    chk("wr_count", wr - wr_s, exp_err || n == 0 ? 0 : 1);
    if (!exp_err && n != 0) chk("wr_data", last_wd, 32'(b));
    chk("bus_rules", viol - viol_s, 0);
  endtask
  initial begin
    int hs, c;
    resetn = 1'b0; start = 1'b0; base_addr = '0; length = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < 2048; i++) ram[i] = 32'(i * 3);
    tick();
    tick();
    chk_reset("reset");
    resetn = 1'b1;
    tick();
    run_job(10, 4, 0, 0, 0);
    run_job(10, 4, 1, 0, 0);
    bad_id = 1'b1;
    run_job(10, 4, 0, 1, 0);
    bad_id = 1'b0;
    run_job(2046, 4, 0, 0, 0);
    run_job(77, 0, 0, 0, 0);
    run_job(100, 3, 0, 0, 1);
    // Async reset while word 2 of 5 is held in OUT.
    start = 1'b1; base_addr = 11'd300; length = 12'd5;
    tick();
    start = 1'b0;
    hs = 0; c = 0;
    while (c < 100) begin
      bus.out_ready = hs < 1;
      if (bus.out_valid === 1'b1 && hs == 1) break;
      if (bus.out_valid === 1'b1 && bus.out_ready) hs++;
      tick();
      c++;
    end
    chk("reach_word2", 32'(c < 100), 1);
    #2 resetn = 1'b0;
    #1 chk_reset("midreset");
    tick();
    resetn = 1'b1;
    tick();
    run_job(300, 5, 0, 0, 0);
    for (int i = 0; i < 2048; i++) ram[i] = $urandom;
    for (int k = 0; k < 6; k++) run_job($urandom_range(0, 2047), $urandom_range(1, 6), 2, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
